// File: rtl/fetch_sequencer.sv
// Program-counter and fetch controller: launches one of four ROM-resident programs,
// steps/branches the PC, and stops on the halt encoding. Optional RUN-cycle counter
// is built only when FETCH_CYCLE_COUNT_EN is defined.
module fetch_sequencer #(
    parameter int          IW        = 16,
    parameter int          DW        = 9,
    parameter logic [DW-1:0] HALT_INST = 9'h1FF,
    parameter int unsigned BASE0     = 0,
    parameter int unsigned BASE1     = 256,
    parameter int unsigned BASE2     = 512,
    parameter int unsigned BASE3     = 768
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [1:0]    ProgSel,
    input  logic [DW-1:0] InstOut,
    input  logic          Stall,
    input  logic          BranchEn,
    input  logic          BranchRel,
    input  logic [IW-1:0] Target,
    output logic [IW-1:0] InstAddress,
    output logic          InstValid,
    output logic          Running,
    output logic          Ack,
    output logic [15:0]   CycleCount
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] pc_q, pc_d;
    logic [IW-1:0] base_sel;
    logic          launch;

    always_comb begin
        base_sel = IW'(BASE0);
        case (ProgSel)
            2'd0:    base_sel = IW'(BASE0);
            2'd1:    base_sel = IW'(BASE1);
            2'd2:    base_sel = IW'(BASE2);
            default: base_sel = IW'(BASE3);
        endcase
    end

    // Start is only honoured outside RUN; in RUN it is deliberately ignored.
    assign launch = Start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (launch) begin
                    state_d = ST_RUN;
                    pc_d    = base_sel;
                end
            end
            ST_RUN: begin
                // Halt takes priority over a branch so the PC parks on the halt address.
                if (!Stall) begin
                    if (InstOut == HALT_INST) begin
                        state_d = ST_DONE;
                    end else if (BranchEn) begin
                        pc_d = BranchRel ? (pc_q + Target) : Target;
                    end else begin
                        pc_d = pc_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign InstAddress = pc_q;
    assign Running     = (state_q == ST_RUN);
    assign InstValid   = Running && !Stall;
    assign Ack         = (state_q == ST_DONE);

`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0] cycle_count_q, cycle_count_d;

    // Counts every RUN edge, stalled or not, and saturates rather than wrapping.
    always_comb begin
        cycle_count_d = cycle_count_q;
        if (launch) begin
            cycle_count_d = '0;
        end else if (Running && (cycle_count_q != 16'hFFFF)) begin
            cycle_count_d = cycle_count_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cycle_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
        end
    end

    assign CycleCount = cycle_count_q;
`else
    assign CycleCount = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural program model.
module tb_fetch_sequencer;

    localparam logic [8:0] HALT = 9'h1FF;
`ifdef FETCH_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        Clk       = 1'b0;
    logic        Reset     = 1'b0;
    logic        Start     = 1'b0;
    logic [1:0]  ProgSel   = 2'd0;
    logic        Stall     = 1'b0;
    logic        BranchEn  = 1'b0;
    logic        BranchRel = 1'b0;
    logic [15:0] Target    = 16'd0;
    logic [8:0]  InstOut;
    logic [15:0] InstAddress;
    logic        InstValid;
    logic        Running;
    logic        Ack;
    logic [15:0] CycleCount;

    logic [8:0] rom [0:65535];

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Model: phase 0 = waiting for a program, 1 = fetching, 2 = finished.
    int          m_phase = 0;
    int unsigned m_pc    = 0;
    int unsigned m_cnt   = 0;

    fetch_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel),
        .InstOut(InstOut), .Stall(Stall), .BranchEn(BranchEn),
        .BranchRel(BranchRel), .Target(Target), .InstAddress(InstAddress),
        .InstValid(InstValid), .Running(Running), .Ack(Ack), .CycleCount(CycleCount)
    );

    assign InstOut = rom[InstAddress];

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic st, input logic [1:0] sel,
                                 input logic stl, input logic ben, input logic brel,
                                 input logic [15:0] tgt);
        Reset = rst; Start = st; ProgSel = sel; Stall = stl;
        BranchEn = ben; BranchRel = brel; Target = tgt;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    always @(posedge Clk) begin
        if (Reset) begin
            m_phase = 0; m_pc = 0; m_cnt = 0;
        end else if (m_phase == 1) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (!Stall) begin
                if (rom[m_pc] == HALT) m_phase = 2;
                else if (BranchEn && BranchRel) m_pc = (m_pc + Target) % 65536;
                else if (BranchEn) m_pc = Target;
                else m_pc = (m_pc + 1) % 65536;
            end
        end else if (Start) begin
            m_phase = 1; m_pc = ProgSel * 256; m_cnt = 0;
        end
    end

    always @(negedge Clk) begin
        if (check_en) begin
            checkOutput("m_addr",    InstAddress, m_pc);
            checkOutput("m_running", Running,     m_phase == 1);
            checkOutput("m_valid",   InstValid,   (m_phase == 1) && !Stall);
            checkOutput("m_ack",     Ack,         m_phase == 2);
            checkOutput("m_count",   CycleCount,  CNT_EN ? m_cnt : 0);
        end
    end

    initial begin
        for (int a = 0; a < 65536; a++) rom[a] = 9'h000;
        rom[256] = 9'h012; rom[257] = 9'h0A5; rom[258] = 9'h1FE; rom[259] = HALT;
        rom[40]  = HALT;

        applyStimulus(1, 0, 0, 0, 0, 0, 0); tick();
        check_en = 1'b1;
        checkOutput("rst_pc", InstAddress, 0);
        checkOutput("rst_ack", Ack, 0);
        checkOutput("rst_running", Running, 0);
        checkOutput("rst_valid", InstValid, 0);
        checkOutput("rst_count", CycleCount, 0);

        applyStimulus(0, 1, 1, 0, 0, 0, 0); tick();
        checkOutput("t1_pc256", InstAddress, 256);
        checkOutput("t1_valid", InstValid, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick(); checkOutput("t1_pc257", InstAddress, 257);
        tick(); checkOutput("t1_pc258", InstAddress, 258);
        tick(); checkOutput("t1_pc259", InstAddress, 259);
        tick();
        checkOutput("t1_ack", Ack, 1);
        checkOutput("t1_pc_hold", InstAddress, 259);
        checkOutput("t1_running", Running, 0);
        checkOutput("t1_count", CycleCount, CNT_EN ? 4 : 0);

        applyStimulus(0, 1, 1, 0, 0, 0, 0); tick();
        checkOutput("t2_ack_drop", Ack, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 16'd300); tick();
        checkOutput("t2_abs300", InstAddress, 300);
        applyStimulus(0, 0, 0, 0, 1, 1, 16'hFFFB); tick();
        checkOutput("t2_rel_m5", InstAddress, 295);
        applyStimulus(0, 0, 0, 0, 1, 0, 16'd10); tick();
        checkOutput("t2_abs10", InstAddress, 10);
        applyStimulus(0, 0, 0, 0, 1, 0, 16'd20); tick();
        checkOutput("t3_pc20", InstAddress, 20);

        applyStimulus(0, 0, 0, 1, 1, 0, 16'd99);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t3_stall_pc", InstAddress, 20);
            checkOutput("t3_stall_valid", InstValid, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0); #1;
        checkOutput("t3_valid_back", InstValid, 1);
        tick(); checkOutput("t3_pc21", InstAddress, 21);

        applyStimulus(0, 0, 0, 0, 1, 0, 16'd40); tick();
        checkOutput("t4_pc40", InstAddress, 40);
        applyStimulus(0, 0, 0, 0, 1, 0, 16'd0); tick();
        checkOutput("t4_ack", Ack, 1);
        checkOutput("t4_pc_hold", InstAddress, 40);
        applyStimulus(0, 1, 2, 0, 0, 0, 0); tick();
        checkOutput("t4_ack_drop", Ack, 0);
        checkOutput("t4_pc512", InstAddress, 512);

        applyStimulus(0, 0, 0, 0, 1, 0, 16'd600); tick();
        checkOutput("t5_pc600", InstAddress, 600);
        applyStimulus(1, 0, 0, 0, 0, 0, 0); tick();
        checkOutput("t5_rst_pc", InstAddress, 0);
        checkOutput("t5_rst_running", Running, 0);
        checkOutput("t5_rst_ack", Ack, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0); tick();
        checkOutput("t5_run", Running, 1);
        applyStimulus(0, 1, 3, 0, 0, 0, 0); tick();
        checkOutput("t5_start_ignored", InstAddress, 1);

        applyStimulus(0, 0, 0, 0, 1, 0, 16'hFFFF); tick();
        checkOutput("t6_pcffff", InstAddress, 16'hFFFF);
        applyStimulus(0, 0, 0, 0, 0, 0, 0); tick();
        checkOutput("t6_wrap", InstAddress, 0);

`ifdef FETCH_CYCLE_COUNT_EN
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        repeat (65540) tick();
        checkOutput("t6_saturate", CycleCount, 16'hFFFF);
`endif

        applyStimulus(1, 0, 0, 0, 0, 0, 0); tick();
        for (int a = 0; a < 65536; a++) begin
            rom[a] = ($urandom_range(0, 31) == 0) ? HALT : 9'($urandom_range(0, 510));
        end
        for (int i = 0; i < 4000; i++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 7) == 0,
                          2'($urandom_range(0, 3)),
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 5) == 0,
                          $urandom_range(0, 1) == 1,
                          ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15) - 8)
                                                      : 16'($urandom_range(0, 65535)));
            tick();
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge Clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
